// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures ALU results, resolves BEQ/BNE at accept,
// and hands entries to MEM through a 2-entry skid buffer (head + skid).
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [REGW-1:0] rd,
  input  logic [XLEN-1:0] br_target,
  input  logic [5:0]      ctl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_r,
  output logic [XLEN-1:0] out_store,
  output logic [REGW-1:0] out_rd,
  output logic [3:0]      out_ctl,
  output logic            br_taken,
  output logic [XLEN-1:0] br_pc
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            out_valid_r;
  logic            in_ready_r;
  logic            accept_s;
  logic            pop_s;
  logic            taken_s;
  logic            load_h_new_s;
  logic            load_s_new_s;
  logic            load_h_skid_s;
  logic [3:0]      new_ctl_s;

  logic [XLEN-1:0] head_res_r;
  logic [XLEN-1:0] head_store_r;
  logic [REGW-1:0] head_rd_r;
  logic [3:0]      head_ctl_r;
  logic [XLEN-1:0] skid_res_r;
  logic [XLEN-1:0] skid_store_r;
  logic [REGW-1:0] skid_rd_r;
  logic [3:0]      skid_ctl_r;
  logic            br_taken_r;
  logic [XLEN-1:0] br_pc_r;

  assign accept_s  = in_valid & in_ready_r & ~flush;
  assign pop_s     = out_valid_r & out_ready;
  // Both beq and bne set is illegal and resolves as not taken.
  assign taken_s   = accept_s & ~(ctl[1] & ctl[0]) &
                     ((ctl[1] & alu_zero) | (ctl[0] & ~alu_zero));
  assign new_ctl_s = {ctl[5] & (rd != {REGW{1'b0}}), ctl[4:2]};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_r     = head_res_r;
  assign out_store = head_store_r;
  assign out_rd    = head_rd_r;
  assign out_ctl   = head_ctl_r;
  assign br_taken  = br_taken_r;
  assign br_pc     = br_pc_r;

  // Next-state and load-select decode for the skid buffer.
  always_comb begin
    state_s       = state_r;
    load_h_new_s  = 1'b0;
    load_s_new_s  = 1'b0;
    load_h_skid_s = 1'b0;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            load_h_new_s = 1'b1;
            state_s      = ONE;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            load_h_new_s = 1'b1;
            state_s      = ONE;
          end else if (accept_s) begin
            load_s_new_s = 1'b1;
            state_s      = FULL;
          end else if (pop_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            load_h_skid_s = 1'b1;
            state_s       = ONE;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State plus registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s != EMPTY);
      in_ready_r  <= (state_s != FULL);
    end
  end

  // Head register: loads a new entry or promotes the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_res_r   <= {XLEN{1'b0}};
      head_store_r <= {XLEN{1'b0}};
      head_rd_r    <= {REGW{1'b0}};
      head_ctl_r   <= 4'd0;
    end else if (load_h_new_s) begin
      head_res_r   <= alu_r;
      head_store_r <= rs2_data;
      head_rd_r    <= rd;
      head_ctl_r   <= new_ctl_s;
    end else if (load_h_skid_s) begin
      head_res_r   <= skid_res_r;
      head_store_r <= skid_store_r;
      head_rd_r    <= skid_rd_r;
      head_ctl_r   <= skid_ctl_r;
    end
  end

  // Skid register: parks an entry while MEM stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_res_r   <= {XLEN{1'b0}};
      skid_store_r <= {XLEN{1'b0}};
      skid_rd_r    <= {REGW{1'b0}};
      skid_ctl_r   <= 4'd0;
    end else if (load_s_new_s) begin
      skid_res_r   <= alu_r;
      skid_store_r <= rs2_data;
      skid_rd_r    <= rd;
      skid_ctl_r   <= new_ctl_s;
    end
  end

  // Branch redirect pulse, one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_r <= 1'b0;
      br_pc_r    <= {XLEN{1'b0}};
    end else begin
      br_taken_r <= taken_s;
      if (taken_s) begin
        br_pc_r <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed test-plan steps followed by
// random traffic, compared against a queue-based reference model.
module tb_ex_mem_stage;

  typedef struct {
    logic [31:0] r;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, alu_zero, out_valid, out_ready, br_taken;
  logic [31:0] alu_r, rs2_data, br_target, out_r, out_store, br_pc;
  logic [4:0]  rd, out_rd;
  logic [5:0]  ctl;
  logic [3:0]  out_ctl;

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];
  entry_t zero_e;
  logic        exp_br;
  logic [31:0] exp_pc;
  logic        rst_seen;

  ex_mem_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_r(alu_r), .alu_zero(alu_zero), .rs2_data(rs2_data), .rd(rd),
    .br_target(br_target), .ctl(ctl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_store(out_store), .out_rd(out_rd), .out_ctl(out_ctl),
    .br_taken(br_taken), .br_pc(br_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [31:0] tgt,
                       input logic [4:0] d, input logic [5:0] c);
    in_valid  = v;
    alu_r     = r;
    alu_zero  = (r == 32'd0);
    rs2_data  = ~r;
    rd        = d;
    br_target = tgt;
    ctl       = c;
  endtask

  // Advance one clock: update the FIFO model from the applied inputs, then compare.
  task automatic tick();
    bit     acc, pop, tk;
    entry_t e, shown;
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() > 0) && out_ready;
    tk  = acc && (ctl[1] != ctl[0]) && (ctl[1] ? alu_zero : !alu_zero);
    e.r = alu_r; e.st = rs2_data; e.rd = rd;
    e.ctl = {ctl[5] && (rd != 5'd0), ctl[4:2]};
    if (rst) begin
      q.delete();
      exp_br = 1'b0; exp_pc = 32'd0; rst_seen = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      if (acc) begin
        q.push_back(e);
        rst_seen = 1'b0;
      end
      exp_br = tk;
      if (tk) exp_pc = br_target;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("br_taken", {31'd0, br_taken}, {31'd0, exp_br});
    if (exp_br || rst_seen) chk("br_pc", br_pc, exp_pc);
    if (q.size() > 0 || rst_seen) begin
      shown = (q.size() > 0) ? q[0] : zero_e;
      chk("out_r", out_r, shown.r);
      chk("out_store", out_store, shown.st);
      chk("out_rd", {27'd0, out_rd}, {27'd0, shown.rd});
      chk("out_ctl", {28'd0, out_ctl}, {28'd0, shown.ctl});
    end
  endtask

  initial begin
    zero_e.r = 32'd0; zero_e.st = 32'd0; zero_e.rd = 5'd0; zero_e.ctl = 4'd0;
    exp_br = 1'b0; exp_pc = 32'd0; rst_seen = 1'b1;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0);
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 * (i + 1), 32'd0, 5'd1, 6'b100000);
      tick();
      chk("stream_r", out_r, 32'h10 * (i + 1));
      chk("stream_rdy", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0);
    tick();

    // Backpressure into skid, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'd0, 5'd2, 6'b100000); tick();
    drive(1'b1, 32'hB, 32'd0, 5'd3, 6'b100000); tick();
    chk("skid_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("skid_head", out_r, 32'hA);
    out_ready = 1'b1;
    drive(1'b1, 32'hC, 32'd0, 5'd4, 6'b100000); tick();
    chk("skid_pop1", out_r, 32'hB);
    chk("skid_rdy_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("skid_c", out_r, 32'hC);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0); tick();

    // Branch resolution
    drive(1'b1, 32'd0, 32'h40, 5'd0, 6'b000010); tick();
    chk("beq_taken", {31'd0, br_taken}, 32'd1);
    chk("beq_pc", br_pc, 32'h40);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0); tick();
    chk("beq_pulse_end", {31'd0, br_taken}, 32'd0);
    drive(1'b1, 32'd0, 32'h80, 5'd0, 6'b000001); tick();
    chk("bne_zero", {31'd0, br_taken}, 32'd0);
    drive(1'b1, 32'd5, 32'h84, 5'd0, 6'b000001); tick();
    chk("bne_nz", {31'd0, br_taken}, 32'd1);
    chk("bne_pc", br_pc, 32'h84);
    drive(1'b1, 32'd0, 32'h88, 5'd0, 6'b000011); tick();
    chk("both_illegal", {31'd0, br_taken}, 32'd0);

    // x0 suppression
    drive(1'b1, 32'hDEAD_BEEF, 32'd0, 5'd0, 6'b100000); tick();
    chk("x0_ctl", {28'd0, out_ctl}, 32'd0);
    chk("x0_r", out_r, 32'hDEAD_BEEF);
    drive(1'b1, 32'd1, 32'd0, 5'd5, 6'b100000); tick();
    chk("rd5_ctl", {28'd0, out_ctl}, 32'h8);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0); tick();

    // Flush while FULL with a taken beq incoming
    out_ready = 1'b0;
    drive(1'b1, 32'h111, 32'd0, 5'd2, 6'b100000); tick();
    drive(1'b1, 32'd5, 32'h200, 5'd0, 6'b000001); tick();
    chk("pre_flush_br", {31'd0, br_taken}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 32'd0, 32'h300, 5'd0, 6'b000010); tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    chk("flush_nobr", {31'd0, br_taken}, 32'd0);

    // Reset mid-operation
    drive(1'b1, 32'h55, 32'd0, 5'd6, 6'b101000); tick();
    drive(1'b1, 32'd0, 32'h400, 5'd0, 6'b000010); tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 6'd0); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_br", {31'd0, br_taken}, 32'd0);
    chk("rst_r", out_r | out_store | {27'd0, out_rd} | {28'd0, out_ctl} | br_pc, 32'd0);
    out_ready = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rv;
      rv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive($urandom_range(0, 3) != 0, rv, $urandom, 5'($urandom_range(0, 7)), 6'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
